axis_traffic_checker: RTL and testbench

- Synthesizable AXI-Stream subordinate (Target) traffic sink for a tile's s_axis side; it consumes streams that the NI's Manager interface delivers out of the NoC.
- Checks tdest, packet length and a deterministic per-TID data pattern, and counts packets and errors.
- Companion of the traffic-generating initiator side, and the synthesizable replacement for the subordinate VIP in hardware NoC runs.

---
 rtl/axis_traffic_pkg.sv | 41 ++++
 rtl/axis_traffic_lfsr.sv | 42 ++++
 rtl/axis_traffic_checker.sv | 207 ++++++++++++++++++++
 tb/tb_axis_traffic_checker.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_traffic_pkg.sv
// ----------------------------------------------------------------------------
// axis_traffic_pkg
//   Shared definitions for the AXI-Stream traffic checker (and the matching
//   traffic generator):
//     - state_e        : checker FSM states
//     - ERR_*          : bit positions inside the 4-bit error flag vector
//     - LFSR_TAPS      : Galois tap mask for x^16 + x^14 + x^13 + x^11
//     - exp_data()     : deterministic per-TID payload pattern
//     - lfsr_next()    : one step of the 16-bit Galois LFSR
// ----------------------------------------------------------------------------
package axis_traffic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BODY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int ERR_DEST      = 0;
  localparam int ERR_DATA      = 1;
  localparam int ERR_LEN_SHORT = 2;
  localparam int ERR_LEN_LONG  = 3;
  localparam int ERR_W         = 4;

  // Right-shifting Galois form: bit 0 is the output, taps at 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Pattern value before truncation to the tdata width. seq is 16 bits and
  // beat_idx/pkt_len are 32 bits, so 64 bits never overflows and truncating
  // (or zero-extending) to any tdata width yields the value mod 2**width.
  function automatic logic [63:0] exp_data(input logic [15:0] seq,
                                           input logic [31:0] pkt_len,
                                           input logic [31:0] beat_idx);
    return (64'(seq) * 64'(pkt_len)) + 64'(beat_idx);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/axis_traffic_lfsr.sv
// ----------------------------------------------------------------------------
// axis_traffic_lfsr
//   16-bit Galois LFSR (x^16 + x^14 + x^13 + x^11). Loads Seed on reset and
//   advances one step per cycle while en_i is high.
//   Ports:
//     clk_i   : clock
//     rst_i   : synchronous active-high reset (loads Seed)
//     en_i    : step enable
//     state_o : current LFSR state
// ----------------------------------------------------------------------------
module axis_traffic_lfsr
  import axis_traffic_pkg::*;
#(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/axis_traffic_checker.sv
// ----------------------------------------------------------------------------
// axis_traffic_checker
//   AXI-Stream subordinate traffic sink. Accepts packets, checks tdest on the
//   first beat, the per-TID payload pattern and the packet length, and keeps
//   packet / error statistics.
//
//   Handshake: a beat transfers on a rising edge where s_axis_tvalid and
//   s_axis_tready are both high. s_axis_tready is a register and never depends
//   combinationally on s_axis_tvalid; payload inputs are only looked at on
//   transfer cycles.
//
//   Ports:
//     clk_s_axis_i    : clock
//     rst_s_axis_i    : synchronous active-high reset
//     enable_i        : low forces tready low (stall, state kept)
//     s_axis_*        : AXI-Stream subordinate inputs, s_axis_tready output
//     pkt_count_o     : packets closed (good or bad)
//     err_count_o     : erroneous packets, saturating
//     err_flags_o     : sticky {len_long, len_short, data, dest}
//     first_err_tid_o : tid of the first erroneous packet
//     done_o          : sticky, pkt_count_o >= ExpectedPackets
// ----------------------------------------------------------------------------
module axis_traffic_checker
  import axis_traffic_pkg::*;
#(
  parameter int          TDataWidth         = 32,
  parameter int          TIdWidth           = 2,
  parameter int          TDestWidth         = 4,
  parameter int          OwnAddress         = 0,
  parameter int          PacketLength       = 8,
  parameter int          ExpectedPackets    = 64,
  parameter int          BackpressureEnable = 0,
  parameter logic [15:0] LfsrSeed           = 16'hACE1
) (
  input  logic                  clk_s_axis_i,
  input  logic                  rst_s_axis_i,
  input  logic                  enable_i,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [TDataWidth-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [TIdWidth-1:0]   s_axis_tid,
  input  logic [TDestWidth-1:0] s_axis_tdest,
  output logic [31:0]           pkt_count_o,
  output logic [15:0]           err_count_o,
  output logic [ERR_W-1:0]      err_flags_o,
  output logic [TIdWidth-1:0]   first_err_tid_o,
  output logic                  done_o
);

  localparam int                  NumTids    = 1 << TIdWidth;
  localparam logic [TDestWidth-1:0] OwnDest  = TDestWidth'(OwnAddress);
  localparam logic [31:0]         PktLen     = 32'(PacketLength);
  localparam logic [31:0]         LastIdx    = 32'(PacketLength - 1);
  localparam logic [31:0]         DoneThresh = 32'(ExpectedPackets);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e                state_q;
  logic [31:0]           beat_idx_q;
  logic [TIdWidth-1:0]   cur_tid_q;
  logic [ERR_W-1:0]      pkt_err_q;
  logic [15:0]           seq_q [NumTids];
  logic [31:0]           pkt_count_q;
  logic [15:0]           err_count_q;
  logic [ERR_W-1:0]      err_flags_q;
  logic [TIdWidth-1:0]   first_err_tid_q;
  logic                  done_q;
  logic                  tready_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                  accept;
  logic                  close;
  logic                  in_idle;
  logic                  checking;
  logic [TIdWidth-1:0]   chk_tid;
  logic [31:0]           chk_idx;
  logic [TDataWidth-1:0] exp_word;
  logic [ERR_W-1:0]      beat_err;
  logic [ERR_W-1:0]      pkt_err_d;
  logic [15:0]           lfsr_state;
  logic                  bp_ok;
  logic                  tready_d;

  axis_traffic_lfsr #(
    .Seed (LfsrSeed)
  ) u_lfsr (
    .clk_i   (clk_s_axis_i),
    .rst_i   (rst_s_axis_i),
    .en_i    (enable_i),
    .state_o (lfsr_state)
  );

  always_comb begin
    bp_ok    = 1'b1;
    if (BackpressureEnable != 0) begin
      bp_ok = |(lfsr_state & 16'h0003);
    end
    tready_d = enable_i & bp_ok;
  end

  always_comb begin
    in_idle  = (state_q == ST_IDLE);
    checking = (state_q != ST_DRAIN);
    // The first beat of a packet is checked against its own tid and index 0;
    // later beats against the tid latched at packet start.
    chk_tid  = in_idle ? s_axis_tid : cur_tid_q;
    chk_idx  = in_idle ? 32'd0 : beat_idx_q;
    exp_word = TDataWidth'(exp_data(seq_q[chk_tid], PktLen, chk_idx));
    accept   = s_axis_tvalid & tready_q;
    close    = accept & s_axis_tlast;

    beat_err = '0;
    if (accept && checking) begin
      beat_err[ERR_DEST]      = in_idle && (s_axis_tdest != OwnDest);
      // A tid change mid-packet is reported as a data error.
      beat_err[ERR_DATA]      = (s_axis_tdata != exp_word) ||
                                (!in_idle && (s_axis_tid != cur_tid_q));
      // chk_idx never exceeds LastIdx while checking, so != means "early".
      beat_err[ERR_LEN_SHORT] = s_axis_tlast && (chk_idx != LastIdx);
      beat_err[ERR_LEN_LONG]  = !s_axis_tlast && (chk_idx == LastIdx);
    end
    pkt_err_d = pkt_err_q | beat_err;
  end

  // --------------------------------------------------------------------------
  // Packet FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_s_axis_i) begin
    if (rst_s_axis_i) begin
      state_q    <= ST_IDLE;
      beat_idx_q <= '0;
      cur_tid_q  <= '0;
      pkt_err_q  <= '0;
    end else if (accept) begin
      if (in_idle) begin
        cur_tid_q <= s_axis_tid;
      end
      if (s_axis_tlast) begin
        // Any tlast ends the packet whatever the state; errors were already
        // folded into pkt_err_d for the close bookkeeping below.
        state_q    <= ST_IDLE;
        beat_idx_q <= '0;
        pkt_err_q  <= '0;
      end else begin
        pkt_err_q  <= pkt_err_d;
        beat_idx_q <= chk_idx + 32'd1;
        if (beat_err[ERR_LEN_LONG] || (state_q == ST_DRAIN)) begin
          state_q <= ST_DRAIN;
        end else begin
          state_q <= ST_BODY;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Statistics and per-TID sequence table
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_s_axis_i) begin
    if (rst_s_axis_i) begin
      pkt_count_q     <= '0;
      err_count_q     <= '0;
      err_flags_q     <= '0;
      first_err_tid_q <= '0;
      done_q          <= 1'b0;
      for (int i = 0; i < NumTids; i++) begin
        seq_q[i] <= '0;
      end
    end else begin
      // Looks at the registered count, so done trails the count by a cycle.
      done_q <= done_q | (pkt_count_q >= DoneThresh);
      if (close) begin
        pkt_count_q    <= pkt_count_q + 32'd1;
        seq_q[chk_tid] <= seq_q[chk_tid] + 16'd1;
        if (|pkt_err_d) begin
          err_flags_q <= err_flags_q | pkt_err_d;
          if (err_count_q == 16'd0) begin
            first_err_tid_q <= chk_tid;
          end
          if (err_count_q != 16'hFFFF) begin
            err_count_q <= err_count_q + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_s_axis_i) begin
    if (rst_s_axis_i) begin
      tready_q <= 1'b0;
    end else begin
      tready_q <= tready_d;
    end
  end

  assign s_axis_tready   = tready_q;
  assign pkt_count_o     = pkt_count_q;
  assign err_count_o     = err_count_q;
  assign err_flags_o     = err_flags_q;
  assign first_err_tid_o = first_err_tid_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_axis_traffic_checker.sv
// ----------------------------------------------------------------------------
// tb_axis_traffic_checker
//   Three checker instances sharing one clock:
//     0: no backpressure, PacketLength 8, ExpectedPackets 4
//     1: LFSR backpressure, PacketLength 8, ExpectedPackets 16
//     2: no backpressure, PacketLength 1, ExpectedPackets 2
//   A packet-level reference model (per-TID sequence numbers, counts, sticky
//   flags) supplies the expected statistics.
// ----------------------------------------------------------------------------
module tb_axis_traffic_checker;

  localparam int OWN = 5;
  localparam logic [15:0] SEED = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic        en  [3];
  logic        tv  [3];
  logic        tl  [3];
  logic [31:0] td  [3];
  logic [1:0]  tid [3];
  logic [3:0]  tdst[3];
  logic        tr  [3];
  logic [31:0] pc  [3];
  logic [15:0] ec  [3];
  logic [3:0]  ef  [3];
  logic [1:0]  ft  [3];
  logic        dn  [3];

  int pl_of[3] = '{8, 8, 1};
  int ep_of[3] = '{4, 16, 2};

  axis_traffic_checker #(
    .TDataWidth(32), .TIdWidth(2), .TDestWidth(4), .OwnAddress(OWN),
    .PacketLength(8), .ExpectedPackets(4), .BackpressureEnable(0), .LfsrSeed(SEED)
  ) dut_a (
    .clk_s_axis_i(clk), .rst_s_axis_i(rst[0]), .enable_i(en[0]),
    .s_axis_tvalid(tv[0]), .s_axis_tready(tr[0]), .s_axis_tdata(td[0]),
    .s_axis_tlast(tl[0]), .s_axis_tid(tid[0]), .s_axis_tdest(tdst[0]),
    .pkt_count_o(pc[0]), .err_count_o(ec[0]), .err_flags_o(ef[0]),
    .first_err_tid_o(ft[0]), .done_o(dn[0])
  );

  axis_traffic_checker #(
    .TDataWidth(32), .TIdWidth(2), .TDestWidth(4), .OwnAddress(OWN),
    .PacketLength(8), .ExpectedPackets(16), .BackpressureEnable(1), .LfsrSeed(SEED)
  ) dut_b (
    .clk_s_axis_i(clk), .rst_s_axis_i(rst[1]), .enable_i(en[1]),
    .s_axis_tvalid(tv[1]), .s_axis_tready(tr[1]), .s_axis_tdata(td[1]),
    .s_axis_tlast(tl[1]), .s_axis_tid(tid[1]), .s_axis_tdest(tdst[1]),
    .pkt_count_o(pc[1]), .err_count_o(ec[1]), .err_flags_o(ef[1]),
    .first_err_tid_o(ft[1]), .done_o(dn[1])
  );

  axis_traffic_checker #(
    .TDataWidth(32), .TIdWidth(2), .TDestWidth(4), .OwnAddress(OWN),
    .PacketLength(1), .ExpectedPackets(2), .BackpressureEnable(0), .LfsrSeed(SEED)
  ) dut_c (
    .clk_s_axis_i(clk), .rst_s_axis_i(rst[2]), .enable_i(en[2]),
    .s_axis_tvalid(tv[2]), .s_axis_tready(tr[2]), .s_axis_tdata(td[2]),
    .s_axis_tlast(tl[2]), .s_axis_tid(tid[2]), .s_axis_tdest(tdst[2]),
    .pkt_count_o(pc[2]), .err_count_o(ec[2]), .err_flags_o(ef[2]),
    .first_err_tid_o(ft[2]), .done_o(dn[2])
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  int         m_seq  [3][4];
  int         m_pkt  [3];
  int         m_err  [3];
  logic [3:0] m_flags[3];
  logic [1:0] m_first[3];

  task automatic model_reset(input int s);
    for (int t = 0; t < 4; t++) m_seq[s][t] = 0;
    m_pkt[s] = 0; m_err[s] = 0; m_flags[s] = 4'h0; m_first[s] = 2'd0;
  endtask

  // Error flags follow from the packet as a whole: its length against the
  // nominal length, whether beat 0 had the wrong tdest, and whether any beat
  // inside the nominal length carried wrong data or a foreign tid.
  task automatic model_packet(input int s, input logic [1:0] t, input int len,
                              input bit dest_bad, input bit data_bad);
    logic [3:0] f;
    f = {len > pl_of[s], len < pl_of[s], data_bad, dest_bad};
    m_pkt[s]++;
    m_seq[s][t] = (m_seq[s][t] + 1) % 65536;
    if (f != 4'h0) begin
      if (m_err[s] == 0) m_first[s] = t;
      if (m_err[s] < 65535) m_err[s]++;
      m_flags[s] |= f;
    end
  endtask

  // ---------------- LFSR / tready reference for instance 1 ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic out;
    out = s[0];
    s   = s >> 1;
    if (out) s = s ^ 16'hB400;   // x^16 + x^14 + x^13 + x^11
    return s;
  endfunction

  logic [15:0] m_lfsr;
  logic        exp_rdy_b;
  bit          mon_on = 1'b0;
  int          b_stall_cycles = 0;

  always @(posedge clk) begin
    if (rst[1]) begin
      m_lfsr    <= SEED;
      exp_rdy_b <= 1'b0;
    end else if (en[1]) begin
      exp_rdy_b <= m_lfsr[0] | m_lfsr[1];
      m_lfsr    <= lfsr_step(m_lfsr);
    end else begin
      exp_rdy_b <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("b_tready_lfsr", {31'd0, tr[1]}, {31'd0, exp_rdy_b});
      if (!rst[1] && !tr[1]) b_stall_cycles++;
    end
  end

  // ---------------- driver tasks ----------------
  // All driving happens 1 time unit after a rising edge.
  task automatic do_reset(input int s);
    rst[s] = 1'b1; tv[s] = 1'b0; tl[s] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("rst%0d_tready", s), {31'd0, tr[s]}, 32'd0);
    chk($sformatf("rst%0d_pkt", s), pc[s], 32'd0);
    chk($sformatf("rst%0d_err", s), {16'd0, ec[s]}, 32'd0);
    chk($sformatf("rst%0d_flags", s), {28'd0, ef[s]}, 32'd0);
    chk($sformatf("rst%0d_first", s), {30'd0, ft[s]}, 32'd0);
    chk($sformatf("rst%0d_done", s), {31'd0, dn[s]}, 32'd0);
    @(posedge clk); #1;
    rst[s] = 1'b0;
    model_reset(s);
  endtask

  task automatic send_beat(input int s, input logic [31:0] d, input logic [1:0] t,
                           input logic [3:0] de, input bit last, input int gap_max);
    int n;
    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    td[s] = d; tid[s] = t; tdst[s] = de; tl[s] = last; tv[s] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (tr[s]) break;
      n++;
      if (n >= 300) begin
        checks++; failures++;
        $display("FAIL accept_timeout inst=%0d actual=ready_low required=ready_high", s);
        break;
      end
    end
    @(posedge clk); #1;
    tv[s] = 1'b0; tl[s] = 1'b0;
  endtask

  // swap: beat index carrying a foreign tid (-1 none); stall: beat index before
  // which enable is dropped for a few cycles (-1 none).
  task automatic send_packet(input int s, input logic [1:0] t, input int len,
                             input bit dest_bad, input logic [31:0] bad_mask,
                             input int swap, input int gap_max, input int stall);
    int  sq;
    bit  data_bad;
    logic [31:0] d;
    logic [1:0]  bt;
    logic [3:0]  de;
    sq = m_seq[s][t];
    data_bad = 1'b0;
    for (int i = 0; i < len; i++) begin
      d  = 32'(sq * pl_of[s] + i);
      bt = t;
      de = (i == 0 && dest_bad) ? 4'(OWN + 1) : 4'(OWN);
      if (bad_mask[i]) begin
        d = ~d;
        if (i < pl_of[s]) data_bad = 1'b1;
      end
      if (i == swap) begin
        bt = t + 2'd1;
        if (i < pl_of[s]) data_bad = 1'b1;
      end
      if (i == stall) begin
        en[s] = 1'b0;
        @(posedge clk); #1;
        td[s] = d; tid[s] = bt; tdst[s] = de; tl[s] = (i == len - 1); tv[s] = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("stall_tready", {31'd0, tr[s]}, 32'd0);
        end
        chk("stall_pkt", pc[s], 32'(m_pkt[s]));
        @(posedge clk); #1;
        tv[s] = 1'b0;
        en[s] = 1'b1;
      end
      send_beat(s, d, bt, de, (i == len - 1), gap_max);
    end
    model_packet(s, t, len, dest_bad, data_bad);
  endtask

  // Counters one cycle after the closing beat; done one cycle later still.
  task automatic check_outputs(input int s, input string tag);
    @(negedge clk);
    chk({tag, "_pkt"}, pc[s], 32'(m_pkt[s]));
    chk({tag, "_err"}, {16'd0, ec[s]}, 32'(m_err[s]));
    chk({tag, "_flags"}, {28'd0, ef[s]}, {28'd0, m_flags[s]});
    chk({tag, "_first"}, {30'd0, ft[s]}, {30'd0, m_first[s]});
    chk({tag, "_done_lat"}, {31'd0, dn[s]}, {31'd0, (m_pkt[s] - 1) >= ep_of[s]});
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, dn[s]}, {31'd0, m_pkt[s] >= ep_of[s]});
    @(posedge clk); #1;
  endtask

  // ---------------- directed vector table (instance 0) ----------------
  typedef struct {
    bit          rst_before;
    logic [1:0]  t;
    int          len;
    bit          dest_bad;
    logic [31:0] bad_mask;
    int          swap;
    logic [31:0] e_pkt;
    logic [15:0] e_err;
    logic [3:0]  e_flags;
    logic [1:0]  e_first;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int s = 0; s < 3; s++) begin
      rst[s] = 1'b1; en[s] = 1'b1; tv[s] = 1'b0; tl[s] = 1'b0;
      td[s] = '0; tid[s] = '0; tdst[s] = '0;
      model_reset(s);
    end

    //            rst  tid len dbad mask     swap pkt  err    flags    first
    vecs[0]  = '{1'b1, 2'd0, 8,  1'b0, 32'h0,  -1, 32'd1, 16'd0, 4'b0000, 2'd0};
    vecs[1]  = '{1'b0, 2'd0, 8,  1'b0, 32'h0,  -1, 32'd2, 16'd0, 4'b0000, 2'd0};
    vecs[2]  = '{1'b0, 2'd0, 8,  1'b0, 32'h0,  -1, 32'd3, 16'd0, 4'b0000, 2'd0};
    vecs[3]  = '{1'b0, 2'd0, 8,  1'b0, 32'h0,  -1, 32'd4, 16'd0, 4'b0000, 2'd0};
    vecs[4]  = '{1'b0, 2'd1, 8,  1'b0, 32'h0,  -1, 32'd5, 16'd0, 4'b0000, 2'd0};
    vecs[5]  = '{1'b0, 2'd2, 8,  1'b0, 32'h0,  -1, 32'd6, 16'd0, 4'b0000, 2'd0};
    vecs[6]  = '{1'b0, 2'd1, 8,  1'b0, 32'h0,  -1, 32'd7, 16'd0, 4'b0000, 2'd0};
    vecs[7]  = '{1'b0, 2'd0, 6,  1'b0, 32'h0,  -1, 32'd8, 16'd1, 4'b0100, 2'd0};
    vecs[8]  = '{1'b0, 2'd0, 8,  1'b0, 32'h0,  -1, 32'd9, 16'd1, 4'b0100, 2'd0};
    vecs[9]  = '{1'b1, 2'd0, 11, 1'b0, 32'h0,  -1, 32'd1, 16'd1, 4'b1000, 2'd0};
    vecs[10] = '{1'b1, 2'd3, 8,  1'b1, 32'h14, -1, 32'd1, 16'd1, 4'b0011, 2'd3};
    vecs[11] = '{1'b0, 2'd1, 8,  1'b0, 32'h0,  -1, 32'd2, 16'd1, 4'b0011, 2'd3};
    vecs[12] = '{1'b0, 2'd2, 8,  1'b0, 32'h0,   3, 32'd3, 16'd2, 4'b0011, 2'd3};
    vecs[13] = '{1'b0, 2'd2, 8,  1'b0, 32'h0,  -1, 32'd4, 16'd2, 4'b0011, 2'd3};

    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 14; k++) begin
      if (vecs[k].rst_before) do_reset(0);
      send_packet(0, vecs[k].t, vecs[k].len, vecs[k].dest_bad, vecs[k].bad_mask,
                  vecs[k].swap, 0, -1);
      @(negedge clk);
      chk($sformatf("tbl%0d_pkt", k), pc[0], vecs[k].e_pkt);
      chk($sformatf("tbl%0d_err", k), {16'd0, ec[0]}, {16'd0, vecs[k].e_err});
      chk($sformatf("tbl%0d_flags", k), {28'd0, ef[0]}, {28'd0, vecs[k].e_flags});
      chk($sformatf("tbl%0d_first", k), {30'd0, ft[0]}, {30'd0, vecs[k].e_first});
      @(negedge clk);
      chk($sformatf("tbl%0d_done", k), {31'd0, dn[0]}, {31'd0, vecs[k].e_pkt >= 32'd4});
      @(posedge clk); #1;
    end

    // enable dropped mid-packet: stall only, packet still good
    send_packet(0, 2'd1, 8, 1'b0, 32'h0, -1, 0, 4);
    check_outputs(0, "stall");

    // randomized traffic on instance 0
    do_reset(0);
    for (int p = 0; p < 40; p++) begin
      logic [1:0]  t;
      int          len;
      bit          dbad;
      logic [31:0] mask;
      int          swap;
      t    = 2'($urandom_range(0, 3));
      len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 8;
      dbad = ($urandom_range(0, 7) == 0);
      mask = ($urandom_range(0, 5) == 0) ? (32'd1 << $urandom_range(0, 11)) : 32'd0;
      swap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : -1;
      send_packet(0, t, len, dbad, mask, swap, 2, -1);
      check_outputs(0, "rnd");
    end

    // PacketLength 1: every beat is a whole packet
    do_reset(2);
    send_packet(2, 2'd0, 1, 1'b0, 32'h0, -1, 1, -1);
    check_outputs(2, "pl1_ok");
    send_packet(2, 2'd1, 3, 1'b0, 32'h0, -1, 1, -1);
    check_outputs(2, "pl1_long");
    send_packet(2, 2'd1, 1, 1'b0, 32'h0, -1, 1, -1);
    check_outputs(2, "pl1_seq");

    // backpressure instance: LFSR-gated tready, reset during packet 5
    mon_on = 1'b1;
    do_reset(1);
    for (int p = 0; p < 4; p++) begin
      send_packet(1, 2'd0, 8, 1'b0, 32'h0, -1, 0, -1);
      check_outputs(1, "bp_pre");
    end
    for (int i = 0; i < 3; i++) begin
      send_beat(1, 32'(m_seq[1][0] * 8 + i), 2'd0, 4'(OWN), 1'b0, 0);
    end
    do_reset(1);
    for (int p = 0; p < 16; p++) begin
      send_packet(1, 2'd0, 8, 1'b0, 32'h0, -1, 0, -1);
      check_outputs(1, "bp");
    end
    chk("b_saw_stall", {31'd0, b_stall_cycles > 0}, 32'd1);
    mon_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
